// File: rtl/aspiradora_sensor_cmd.sv
// rtl/aspiradora_sensor_cmd.sv - sensor sync/debounce front-end and on/cleaning/evading command FSM
// Raw inputs are synchronized and debounced; a Moore FSM turns the filtered levels into command levels.
module aspiradora_sensor_cmd #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLEAN_MIN       = 16,
    parameter int EVADE_CYCLES    = 8,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic power_off,
    input  logic btn_raw,
    input  logic dirt_raw,
    input  logic bump_raw,
    output logic on,
    output logic cleaning,
    output logic evading
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_CLEAN = 3'd3;
    localparam logic [2:0] ST_EVADE = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAN_LOAD = CNT_W'(CLEAN_MIN - 1);
    localparam logic [CNT_W-1:0] EVADE_LOAD = CNT_W'(EVADE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    // Bit order in every 3-bit vector: [0]=btn, [1]=dirt, [2]=bump.
    logic [2:0]       raw;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       filt_q, filt_d;
    logic [CNT_W-1:0] deb_cnt_q [3];
    logic [CNT_W-1:0] deb_cnt_d [3];
    logic             btn_prev_q, btn_prev_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] clean_cnt_q, clean_cnt_d;
    logic [CNT_W-1:0] evade_cnt_q, evade_cnt_d;

    logic btn_rise;
    logic dirt_f;
    logic bump_f;

    assign raw      = {bump_raw, dirt_raw, btn_raw};
    assign dirt_f   = filt_q[1];
    assign bump_f   = filt_q[2];
    assign btn_rise = filt_q[0] & ~btn_prev_q;

    // The filtered value toggles on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        filt_d     = filt_q;
        btn_prev_d = filt_q[0];
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                deb_cnt_d[i] = CNT_ZERO;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                filt_d[i]    = ~filt_q[i];
                deb_cnt_d[i] = CNT_ZERO;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clean_cnt_d = clean_cnt_q;
        evade_cnt_d = evade_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_rise) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dirt_f) begin
                    state_d     = ST_CLEAN;
                    clean_cnt_d = CLEAN_LOAD;
                end else if (bump_f) begin
                    state_d     = ST_EVADE;
                    evade_cnt_d = EVADE_LOAD;
                end
            end
            ST_CLEAN: begin
                if (clean_cnt_q == CNT_ZERO) begin
                    if (!dirt_f) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    clean_cnt_d = clean_cnt_q - CNT_ONE;
                end
            end
            ST_EVADE: begin
                // A bump still present keeps restarting the post-bump hold time.
                if (bump_f) begin
                    evade_cnt_d = EVADE_LOAD;
                end else if (evade_cnt_q == CNT_ZERO) begin
                    state_d = ST_RUN;
                end else begin
                    evade_cnt_d = evade_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge power_off) begin
        if (power_off) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            filt_q       <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            deb_cnt_q[2] <= '0;
            btn_prev_q   <= 1'b0;
            state_q      <= ST_IDLE;
            clean_cnt_q  <= '0;
            evade_cnt_q  <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            filt_q       <= filt_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            deb_cnt_q[2] <= deb_cnt_d[2];
            btn_prev_q   <= btn_prev_d;
            state_q      <= state_d;
            clean_cnt_q  <= clean_cnt_d;
            evade_cnt_q  <= evade_cnt_d;
        end
    end

    assign on       = (state_q == ST_START);
    assign cleaning = (state_q == ST_CLEAN);
    assign evading  = (state_q == ST_EVADE);

endmodule

// File: tb/tb_aspiradora_sensor_cmd.sv
// tb/tb_aspiradora_sensor_cmd.sv - directed self-checking bench for aspiradora_sensor_cmd
// Edge k of a scenario is the k-th rising edge after the raw inputs were changed.
module tb_aspiradora_sensor_cmd;

    logic clk       = 1'b0;
    logic power_off = 1'b1;
    logic btn_raw   = 1'b0;
    logic dirt_raw  = 1'b0;
    logic bump_raw  = 1'b0;
    logic on;
    logic cleaning;
    logic evading;

    int vectors     = 0;
    int miscompares = 0;

    int on_n, on_first, cl_n, cl_first, cl_fall, ev_n, ev_first, ev_fall, excl_bad;

    always #5 clk = ~clk;

    aspiradora_sensor_cmd dut (
        .clk       (clk),
        .power_off (power_off),
        .btn_raw   (btn_raw),
        .dirt_raw  (dirt_raw),
        .bump_raw  (bump_raw),
        .on        (on),
        .cleaning  (cleaning),
        .evading   (evading)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges, dropping a raw input after the given edge (0 = never), and records output activity.
    task automatic observe(input int n, input int dirt_off, input int bump_off, input int btn_off);
        on_n = 0; on_first = 0; cl_n = 0; cl_first = 0; cl_fall = 0;
        ev_n = 0; ev_first = 0; ev_fall = 0; excl_bad = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (on) begin
                on_n++;
                if (on_first == 0) on_first = k;
            end
            if (cleaning) begin
                cl_n++;
                if (cl_first == 0) cl_first = k;
            end else if (cl_first != 0 && cl_fall == 0) begin
                cl_fall = k;
            end
            if (evading) begin
                ev_n++;
                if (ev_first == 0) ev_first = k;
            end else if (ev_first != 0 && ev_fall == 0) begin
                ev_fall = k;
            end
            if (int'(on) + int'(cleaning) + int'(evading) > 1) excl_bad++;
            if (k == dirt_off) dirt_raw = 1'b0;
            if (k == bump_off) bump_raw = 1'b0;
            if (k == btn_off)  btn_raw  = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [2:0] pat;
        power_off = 1'b1;
        repeat (2) step();
        vectors++;
        if ({on, cleaning, evading} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state got=%b want=000", {on, cleaning, evading});
        end
        for (int k = 0; k < 8; k++) begin
            pat = 3'(k ^ 5);
            {btn_raw, dirt_raw, bump_raw} = pat;
            step();
            vectors++;
            if ({on, cleaning, evading} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_held k=%0d got=%b want=000", k, {on, cleaning, evading});
            end
        end
        {btn_raw, dirt_raw, bump_raw} = 3'b000;
        step();
        power_off = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_glitch();
        btn_raw = 1'b1;
        observe(20, 0, 0, 3);
        vectors++;
        if (on_n !== 0) begin
            miscompares++;
            $display("FAIL glitch_on_count got=%0d want=0", on_n);
        end
    endtask

    task automatic test_start();
        btn_raw = 1'b1;
        observe(30, 0, 0, 20);
        vectors++;
        if (on_n !== 1) begin
            miscompares++;
            $display("FAIL start_on_count got=%0d want=1", on_n);
        end
        vectors++;
        if (on_first !== 7) begin
            miscompares++;
            $display("FAIL start_on_edge got=%0d want=7", on_first);
        end
    endtask

    task automatic test_second_press();
        btn_raw = 1'b1;
        observe(30, 0, 0, 20);
        vectors++;
        if (on_n !== 0) begin
            miscompares++;
            $display("FAIL run_press_on_count got=%0d want=0", on_n);
        end
    endtask

    task automatic test_clean_min();
        dirt_raw = 1'b1;
        observe(40, 6, 0, 0);
        vectors++;
        if (cl_first !== 7) begin
            miscompares++;
            $display("FAIL clean_min_rise got=%0d want=7", cl_first);
        end
        vectors++;
        if (cl_n !== 16) begin
            miscompares++;
            $display("FAIL clean_min_len got=%0d want=16", cl_n);
        end
        vectors++;
        if (cl_fall !== 23) begin
            miscompares++;
            $display("FAIL clean_min_fall got=%0d want=23", cl_fall);
        end
    endtask

    task automatic test_clean_long();
        dirt_raw = 1'b1;
        observe(60, 40, 0, 0);
        vectors++;
        if (cl_fall !== 47) begin
            miscompares++;
            $display("FAIL clean_long_fall got=%0d want=47", cl_fall);
        end
        vectors++;
        if (cl_n !== 40) begin
            miscompares++;
            $display("FAIL clean_long_len got=%0d want=40", cl_n);
        end
    endtask

    task automatic test_priority();
        dirt_raw = 1'b1;
        bump_raw = 1'b1;
        observe(60, 6, 30, 0);
        vectors++;
        if (cl_first !== 7 || cl_fall !== 23) begin
            miscompares++;
            $display("FAIL prio_clean got=%0d..%0d want=7..23", cl_first, cl_fall);
        end
        vectors++;
        if (ev_first !== 24) begin
            miscompares++;
            $display("FAIL prio_evade_rise got=%0d want=24", ev_first);
        end
        vectors++;
        if (ev_fall !== 44) begin
            miscompares++;
            $display("FAIL prio_evade_fall got=%0d want=44", ev_fall);
        end
        vectors++;
        if (excl_bad !== 0 || on_n !== 0) begin
            miscompares++;
            $display("FAIL prio_exclusive got=%0d/%0d want=0/0", excl_bad, on_n);
        end
    endtask

    task automatic test_evade();
        bump_raw = 1'b1;
        observe(45, 0, 20, 0);
        vectors++;
        if (ev_first !== 7) begin
            miscompares++;
            $display("FAIL evade_rise got=%0d want=7", ev_first);
        end
        vectors++;
        if (ev_fall !== 34) begin
            miscompares++;
            $display("FAIL evade_fall got=%0d want=34", ev_fall);
        end
        vectors++;
        if (ev_n !== 27 || cl_n !== 0) begin
            miscompares++;
            $display("FAIL evade_len got=%0d/%0d want=27/0", ev_n, cl_n);
        end
    endtask

    task automatic test_reset_mid_evade();
        bump_raw = 1'b1;
        repeat (10) step();
        vectors++;
        if (evading !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_evade_pre got=%b want=1", evading);
        end
        #3;
        power_off = 1'b1;
        #1;
        vectors++;
        if ({on, cleaning, evading} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_evade_reset got=%b want=000", {on, cleaning, evading});
        end
        repeat (3) step();
        power_off = 1'b0;
        observe(20, 0, 0, 0);
        vectors++;
        if (on_n !== 0 || ev_n !== 0) begin
            miscompares++;
            $display("FAIL post_reset_idle got=%0d/%0d want=0/0", on_n, ev_n);
        end
        bump_raw = 1'b0;
        btn_raw  = 1'b1;
        observe(25, 0, 0, 15);
        vectors++;
        if (on_n !== 1 || on_first !== 7) begin
            miscompares++;
            $display("FAIL post_reset_press got=%0d@%0d want=1@7", on_n, on_first);
        end
    endtask

    task automatic test_btn_held_through_reset();
        power_off = 1'b1;
        btn_raw   = 1'b1;
        repeat (3) step();
        power_off = 1'b0;
        observe(25, 0, 0, 15);
        vectors++;
        if (on_n !== 1 || on_first !== 7) begin
            miscompares++;
            $display("FAIL held_btn_release got=%0d@%0d want=1@7", on_n, on_first);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start();
        test_second_press();
        test_clean_min();
        test_clean_long();
        test_priority();
        test_evade();
        test_reset_mid_evade();
        test_btn_held_through_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aspiradora_sensor_cmd.md
# aspiradora_sensor_cmd

Sensor front-end and command generator for the vacuum-robot controller. Samples three raw, asynchronous, bouncy inputs: start button, dirt sensor and bump sensor. Synchronizes and debounces them, then tracks the robot's mode with its own FSM. From that FSM it drives the `on`, `cleaning` and `evading` command levels into the robot state machine, with the same priorities and minimum-duration rules that state machine expects.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must differ from its filtered value before the filtered value toggles. Range is 1 or more.
- `CLEAN_MIN`, default 16: minimum cycles `cleaning` stays high per cleaning episode. Range is 1 or more.
- `EVADE_CYCLES`, default 8: cycles `evading` stays high after the filtered bump input falls. Range is 1 or more.
- `CNT_W`, default 8: width of every internal counter. All cycle parameters must be less than 2^CNT_W.
- `clk` input, 1 bit: the single clock; all logic is rising-edge.
- `power_off` input, 1 bit: reset, asynchronous and active-high. Clears all state immediately.
- `btn_raw` input, 1 bit: start button, asynchronous, bouncy.
- `dirt_raw` input, 1 bit: dirt sensor, asynchronous, bouncy.
- `bump_raw` input, 1 bit: bump/obstacle sensor, asynchronous, bouncy.
- `on` output, 1 bit: one-cycle start pulse.
- `cleaning` output, 1 bit: cleaning command level.
- `evading` output, 1 bit: evade command level.

## Operation
- Each raw input passes through a 2-FF synchronizer and then a debounce counter.
  - The counter increments on every edge where the synchronized value differs from the filtered value.
  - It clears on any edge where they are equal.
  - When the count reaches `DEBOUNCE_CYCLES`, the filtered value toggles and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` synchronized cycles never reach the filtered value.
- A registered copy of filtered btn detects its rising edge (`btn_rise`).
- FSM states are IDLE, START, RUN, CLEAN and EVADE. All outputs are Moore: `on` = START, `cleaning` = CLEAN, `evading` = EVADE.
- IDLE:
  - `btn_rise` goes to START; otherwise stay.
  - Dirt and bump are ignored.
- START: lasts exactly one cycle, then RUN unconditionally.
- RUN:
  - filtered dirt = 1 goes to CLEAN.
  - Otherwise, filtered bump = 1 goes to EVADE.
  - Otherwise stay.
  - Dirt has priority over bump.
- CLEAN:
  - Entry loads `clean_cnt` = `CLEAN_MIN`-1; it decrements each cycle and saturates at 0.
  - Exit to RUN when `clean_cnt` = 0 and filtered dirt = 0.
  - Bump is ignored, so `evading` stays 0.
- EVADE:
  - Entry loads `evade_cnt` = `EVADE_CYCLES`-1.
  - While filtered bump = 1 the counter reloads; otherwise it decrements and saturates at 0.
  - Exit to RUN when `evade_cnt` = 0 and filtered bump = 0.
  - Dirt is ignored until back in RUN.
- The button is ignored in every state except IDLE. The only way back to IDLE is `power_off`.
- If dirt or bump is still asserted on return to RUN, RUN lasts exactly one cycle before re-entering the appropriate state.

## Timing
- On `power_off` assertion, asynchronously and immediately:
  - all synchronizer flops, filtered values, the edge register and all counters go to 0;
  - state goes to IDLE;
  - `on`, `cleaning` and `evading` go to 0.
- This also applies mid-operation: any active command drops in the same cycle.
- Latency, with edge 1 being the first rising edge that samples a new raw level:
  - the filtered value changes after edge `DEBOUNCE_CYCLES`+2;
  - the FSM state and outputs change after edge `DEBOUNCE_CYCLES`+3.
- `on` is high for exactly one cycle per debounced button press, regardless of press length.
- `cleaning` stays high for at least `CLEAN_MIN` consecutive cycles per episode. It falls on the edge after filtered dirt is 0 with the counter at 0.
- `evading` stays high from entry until `EVADE_CYCLES` cycles after filtered bump falls.
- `cleaning` and `evading` are never high in the same cycle. `on` is never high together with either of them.
- Button held through `power_off` release: filtered btn starts at 0, so a fresh pulse follows after `DEBOUNCE_CYCLES`+3 edges.

## Test plan
All scenarios use the defaults: D=4, `CLEAN_MIN`=16, `EVADE_CYCLES`=8.
1. Reset:
   - `power_off` pulsed mid-cycle with all raw inputs toggling -> all outputs 0 immediately.
   - Outputs stay 0 while `power_off` is held.
2. Debounce and start:
   - `btn_raw` glitch of 3 cycles -> no `on` pulse.
   - `btn_raw` held 20 cycles -> `on` high exactly 1 cycle, first seen after edge 7.
   - A second press while in RUN -> no pulse.
3. Cleaning minimum:
   - In RUN, `dirt_raw` high 6 cycles -> `cleaning` high exactly 16 cycles.
   - `dirt_raw` high 40 cycles -> `cleaning` falls 7 edges after `dirt_raw` falls.
4. Priority:
   - In RUN, `dirt_raw` and `bump_raw` rise together -> `cleaning` first, `evading` 0 throughout.
   - After cleaning ends with bump still high -> one RUN cycle, then `evading` rises.
5. Evade:
   - `bump_raw` high 20 cycles -> `evading` rises 7 edges after `bump_raw`.
   - `evading` stays high until 8 cycles after filtered bump falls.
6. Reset mid-evade:
   - `power_off` asserted while `evading`=1 -> `evading` 0 at once.
   - After release, no `on` pulse until a new debounced button press.
